// File: rtl/vga_pkg.sv
// Shared VGA-path types and constants: banner selection codes, the
// end-screen FSM state type and the scroll arithmetic helper.
package vga_pkg;

  localparam int unsigned SCREEN_ROWS = 480;
  localparam int unsigned SCREEN_COLS = 640;

  typedef enum logic [1:0] {
    BANNER_NONE = 2'b00,
    BANNER_WIN  = 2'b01,
    BANNER_LOSE = 2'b10
  } banner_sel_t;

  typedef enum logic [1:0] {
    ES_PLAY,
    ES_SCROLL,
    ES_HOLD,
    ES_RELEASE
  } end_state_t;

  // One scroll step towards stop; compared in 13 bits so the row never wraps.
  function automatic logic [11:0] scroll_step(input logic [11:0] row,
                                              input logic [11:0] stop,
                                              input logic [11:0] step);
    if (13'(row) > 13'(stop) + 13'(step)) return row - step;
    else return stop;
  endfunction

endpackage

// File: rtl/end_screen_sequencer_step_timer.sv
// Free-running divider producing a one-cycle tick every TERM_CNT clocks;
// clear holds the count at zero.
module step_timer #(
  parameter int unsigned TERM_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TERM_CNT > 1) ? $clog2(TERM_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERM_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/end_screen_sequencer.sv
// End-of-game banner sequencer: latches win/lose, freezes play, scrolls the
// banner up to its rest row, holds it, then releases on restart.
module end_screen_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned START_ROW  = 480,
  parameter int unsigned STOP_ROW   = 120,
  parameter int unsigned BANNER_COL = 195,
  parameter int unsigned STEP_PX    = 3,
  parameter int unsigned STEP_CLKS  = 1000000,
  parameter int unsigned HOLD_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        win_evt,
  input  logic        lose_evt,
  input  logic        restart,
  output logic [1:0]  banner_sel,
  output logic [11:0] banner_row,
  output logic [11:0] banner_col,
  output logic        game_freeze,
  output logic        game_reset,
  output logic        busy
);

  localparam int unsigned HW = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS);

  end_state_t    state_q, state_d;
  banner_sel_t   sel_q, sel_d;
  logic [11:0]   row_q, row_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          freeze_q, freeze_d;
  logic          greset_q, greset_d;
  logic          busy_q, busy_d;
  logic          tick;
  logic          timer_clr;

  // Holding the timer clear for all of PLAY guarantees a zero count on SCROLL entry.
  assign timer_clr = (state_q == ES_PLAY);

  step_timer #(
    .TERM_CNT(STEP_CLKS)
  ) u_step_timer (
    .clk  (clk),
    .rst_n(rst),
    .clear(timer_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    row_d   = row_q;
    hold_d  = hold_q;
    unique case (state_q)
      ES_PLAY: begin
        if (lose_evt) begin
          state_d = ES_SCROLL;
          sel_d   = BANNER_LOSE;
        end else if (win_evt) begin
          state_d = ES_SCROLL;
          sel_d   = BANNER_WIN;
        end
      end
      ES_SCROLL: begin
        if (tick) begin
          if (row_q == 12'(STOP_ROW)) begin
            state_d = ES_HOLD;
            hold_d  = '0;
          end else begin
            row_d = scroll_step(row_q, 12'(STOP_ROW), 12'(STEP_PX));
          end
        end
      end
      ES_HOLD: begin
        if (tick && (hold_q != HOLD_LAST)) hold_d = hold_q + HW'(1);
        if (restart && (hold_q == HOLD_LAST)) state_d = ES_RELEASE;
      end
      ES_RELEASE: begin
        state_d = ES_PLAY;
        sel_d   = BANNER_NONE;
        row_d   = 12'(START_ROW);
      end
      default: state_d = ES_PLAY;
    endcase
    freeze_d = (state_d != ES_PLAY);
    busy_d   = (state_d != ES_PLAY);
    greset_d = (state_d == ES_RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ES_PLAY;
      sel_q    <= BANNER_NONE;
      row_q    <= 12'(START_ROW);
      hold_q   <= '0;
      freeze_q <= 1'b0;
      greset_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      row_q    <= row_d;
      hold_q   <= hold_d;
      freeze_q <= freeze_d;
      greset_q <= greset_d;
      busy_q   <= busy_d;
    end
  end

  assign banner_sel  = sel_q;
  assign banner_row  = row_q;
  assign banner_col  = 12'(BANNER_COL);
  assign game_freeze = freeze_q;
  assign game_reset  = greset_q;
  assign busy        = busy_q;

endmodule
